// File: rtl/i2c_pkg.sv
// Shared types and default geometry for the I2C frame counter.
package i2c_pkg;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_MAX_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/i2c_slot_counter.sv
// Bit-slot counter with synchronous clear, count enable and a decoded
// terminal-count flag; clear takes priority over enable.
module i2c_slot_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TC_VALUE = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == WIDTH'(TC_VALUE));

endmodule

// File: rtl/i2c_frame_counter.sv
// Tracks bit/byte position through an I2C frame clocked by SCL; every output
// is decoded from registered state so no input reaches an output combinationally.
module i2c_frame_counter
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned MAX_BYTES = DEF_MAX_BYTES,
  localparam int unsigned BW = $clog2(DATA_BITS + 1),
  localparam int unsigned CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          SCL,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] nbytes,
  output logic [BW-1:0] bit_cnt,
  output logic [CW-1:0] byte_cnt,
  output logic          data_phase,
  output logic          ack_phase,
  output logic          byte_tick,
  output logic          frame_done,
  output logic          busy
);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] byte_cnt_q;
  logic [CW-1:0] byte_cnt_d;
  logic [CW-1:0] len_q;
  logic [CW-1:0] len_d;
  logic [CW-1:0] len_sat_c;
  logic          last_byte_c;
  logic          bit_clr_c;
  logic          bit_en_c;
  logic          bit_tc;
  logic [BW-1:0] bit_cnt_w;

  i2c_slot_counter #(
    .WIDTH    (BW),
    .TC_VALUE (DATA_BITS - 1)
  ) u_bit_cnt (
    .clk_i (SCL),
    .rst_i (reset),
    .clr_i (bit_clr_c),
    .en_i  (bit_en_c),
    .cnt_o (bit_cnt_w),
    .tc_o  (bit_tc)
  );

  // Requested length clamped to 1..MAX_BYTES so byte_cnt can never wrap.
  always_comb begin
    len_sat_c = nbytes;
    if (nbytes == '0) begin
      len_sat_c = CW'(1);
    end else if (nbytes > CW'(MAX_BYTES)) begin
      len_sat_c = CW'(MAX_BYTES);
    end
  end

  assign last_byte_c = (byte_cnt_q == (len_q - CW'(1)));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    bit_clr_c  = 1'b0;
    bit_en_c   = 1'b0;

    if (stop) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      bit_clr_c  = 1'b1;
    end else if (start) begin
      state_d    = DATA;
      byte_cnt_d = '0;
      len_d      = len_sat_c;
      bit_clr_c  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          byte_cnt_d = '0;
          bit_clr_c  = 1'b1;
        end
        DATA: begin
          // Counter steps past the last data bit to DATA_BITS for the ACK slot.
          bit_en_c = 1'b1;
          if (bit_tc) begin
            state_d = ACK;
          end
        end
        ACK: begin
          bit_clr_c = 1'b1;
          if (last_byte_c) begin
            state_d = DONE;
          end else begin
            state_d    = DATA;
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          bit_clr_c  = 1'b1;
        end
        default: begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          bit_clr_c  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge SCL or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      len_q      <= CW'(1);
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
    end
  end

  assign bit_cnt    = bit_cnt_w;
  assign byte_cnt   = byte_cnt_q;
  assign data_phase = (state_q == DATA);
  assign ack_phase  = (state_q == ACK);
  assign byte_tick  = (state_q == DATA) && bit_tc;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q == DATA) || (state_q == ACK);

endmodule

// File: tb/tb_i2c_frame_counter.sv
// Directed bench for i2c_frame_counter with DATA_BITS=8, MAX_BYTES=16.
module tb_i2c_frame_counter;

  localparam int unsigned BW = 4;
  localparam int unsigned CW = 5;

  logic          SCL = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [CW-1:0] nbytes;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] byte_cnt;
  logic          data_phase;
  logic          ack_phase;
  logic          byte_tick;
  logic          frame_done;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  i2c_frame_counter #(
    .DATA_BITS (8),
    .MAX_BYTES (16)
  ) dut (
    .SCL        (SCL),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .nbytes     (nbytes),
    .bit_cnt    (bit_cnt),
    .byte_cnt   (byte_cnt),
    .data_phase (data_phase),
    .ack_phase  (ack_phase),
    .byte_tick  (byte_tick),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 SCL = ~SCL;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int b, input int y, input bit d, input bit a,
                                       input bit t, input bit f, input bit u);
    return {18'b0, BW'(b), CW'(y), d, a, t, f, u};
  endfunction

  function automatic logic [31:0] outs();
    return {18'b0, bit_cnt, byte_cnt, data_phase, ack_phase, byte_tick, frame_done, busy};
  endfunction

  task automatic step();
    @(posedge SCL);
    #1;
  endtask

  // Runs until frame_done, counting busy cycles and the highest byte index.
  task automatic run_frame(input int init, output int busy_n, output int max_b, output bit seen);
    busy_n = init;
    max_b  = int'(byte_cnt);
    seen   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (int'(byte_cnt) > max_b) max_b = int'(byte_cnt);
    end
  endtask

  int bn;
  int mb;
  bit seen;
  bit done_any;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    nbytes = '0;
    #2;
    chk("reset_state", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // Two-byte frame, edge by edge
    #10;
    reset  = 1'b0;
    start  = 1'b1;
    nbytes = 5'd2;
    step();
    chk("f2_e1", outs(), pack(0, 0, 1, 0, 0, 0, 1));
    start  = 1'b0;
    nbytes = 5'd0;
    for (int e = 2; e <= 8; e++) begin
      step();
      chk($sformatf("f2_e%0d", e), outs(), pack(e - 1, 0, 1, 0, e == 8, 0, 1));
    end
    step();
    chk("f2_e9_ack", outs(), pack(8, 0, 0, 1, 0, 0, 1));
    step();
    chk("f2_e10", outs(), pack(0, 1, 1, 0, 0, 0, 1));
    for (int e = 11; e <= 17; e++) begin
      step();
      chk($sformatf("f2_e%0d", e), outs(), pack(e - 10, 1, 1, 0, e == 17, 0, 1));
    end
    step();
    chk("f2_e18_ack", outs(), pack(8, 1, 0, 1, 0, 0, 1));
    step();
    chk("f2_e19_done", 32'({data_phase, ack_phase, byte_tick, frame_done, busy}), 32'h02);
    step();
    chk("f2_e20_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-DATA
    start  = 1'b1;
    nbytes = 5'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_pre_bit5", outs(), pack(5, 0, 1, 0, 0, 0, 1));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_immediate", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    @(posedge SCL);
    #3;
    reset = 1'b0;
    done_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_done || busy) done_any = 1'b1;
    end
    chk("rst_no_done", 32'(done_any), 32'd0);

    // Repeated start during ACK of byte 0
    start  = 1'b1;
    nbytes = 5'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("rs_ack0", outs(), pack(8, 0, 0, 1, 0, 0, 1));
    start  = 1'b1;
    nbytes = 5'd3;
    step();
    start = 1'b0;
    chk("rs_restart", outs(), pack(0, 0, 1, 0, 0, 0, 1));
    run_frame(1, bn, mb, seen);
    chk("rs_done_seen", 32'(seen), 32'd1);
    chk("rs_busy_cycles", 32'(bn), 32'd27);
    chk("rs_max_byte", 32'(mb), 32'd2);
    step();
    chk("rs_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // Stop mid-frame at bit 3 of byte 1
    start  = 1'b1;
    nbytes = 5'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("stop_pre", outs(), pack(3, 1, 1, 0, 0, 0, 1));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    done_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (frame_done) done_any = 1'b1;
    end
    chk("stop_no_done", 32'(done_any), 32'd0);
    start  = 1'b1;
    nbytes = 5'd2;
    step();
    start = 1'b0;
    step();
    step();
    chk("ss_pre", outs(), pack(2, 0, 1, 0, 0, 0, 1));
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // Length clamping: 0 -> 1 byte, 20 -> 16 bytes
    start  = 1'b1;
    nbytes = 5'd0;
    step();
    start = 1'b0;
    run_frame(1, bn, mb, seen);
    chk("n0_done_seen", 32'(seen), 32'd1);
    chk("n0_busy_cycles", 32'(bn), 32'd9);
    step();
    start  = 1'b1;
    nbytes = 5'd20;
    step();
    start = 1'b0;
    run_frame(1, bn, mb, seen);
    chk("n20_done_seen", 32'(seen), 32'd1);
    chk("n20_busy_cycles", 32'(bn), 32'd144);
    chk("n20_max_byte", 32'(mb), 32'd15);
    step();
    chk("n20_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // Start during DONE goes straight back into DATA
    start  = 1'b1;
    nbytes = 5'd1;
    step();
    start = 1'b0;
    run_frame(1, bn, mb, seen);
    chk("dr_first_done", 32'(seen), 32'd1);
    start  = 1'b1;
    nbytes = 5'd1;
    step();
    start = 1'b0;
    chk("dr_restart", outs(), pack(0, 0, 1, 0, 0, 0, 1));
    run_frame(1, bn, mb, seen);
    chk("dr_second_done", 32'(seen), 32'd1);
    chk("dr_busy_cycles", 32'(bn), 32'd9);
    step();
    chk("dr_pulse_width", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
